// File: rtl/fm_ctrl_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter.
package fm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int FP_W   = 32;
  localparam int FM_LAT = 8;

  localparam logic [31:0] FP_QNAN    = 32'hFFC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;

endpackage

// File: rtl/fm_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts just after the previous winner, then take the lowest set bit.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rot;
  int               start;
  int               offset;
  int               pos;

  // Doubling the vector lets a plain shift act as a rotate without wrap logic.
  always_comb begin
    start  = (int'(last) + 1) % N_REQ;
    rot    = N_REQ'({req, req} >> start);
    offset = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = i;
    end
    pos    = (start + offset) % N_REQ;
    idx    = ID_W'(pos);
    onehot = '0;
    if (|req) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fm_arbiter.sv
// Round-robin sequencer sharing one fixed-latency FP32 multiplier between
// N_REQ requesters; results come back tagged with the owner's index.
module fm_arbiter
  import fm_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int LAT   = FM_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*32-1:0]   a_in,
  input  logic [N_REQ*32-1:0]   b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_z,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy,
  output logic                  err,
  output logic                  mul_v,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_z,
  input  logic                  mul_valid
);

  localparam int CNT_W = $clog2(LAT);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   id;
  logic [ID_W-1:0]   pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [FP_W-1:0]   op_a;
  logic [FP_W-1:0]   op_b;
  logic [FP_W-1:0]   res_z_q;
  logic              err_q;
  logic              cnt_done;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .last   (last),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign cnt_done = (cnt == CNT_W'(LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)     state_nxt = RUN;
      RUN:     if (cnt_done) state_nxt = CAP;
      CAP:                   state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = (state == IDLE) ? pick_onehot : '0;
    mul_v     = (state == RUN);
    res_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  // The multiplier's phase counter is never reset between operations, so the
  // enable window must be exactly LAT cycles; cnt enforces that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      last    <= ID_W'(N_REQ - 1);
      id      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_z_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            op_a <= a_in[FP_W*int'(pick_idx) +: FP_W];
            op_b <= b_in[FP_W*int'(pick_idx) +: FP_W];
            id   <= pick_idx;
            last <= pick_idx;
          end
        end
        RUN: cnt <= cnt_done ? '0 : cnt + 1'b1;
        CAP: begin
          res_z_q <= mul_z;
          if (!mul_valid) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mul_a  = op_a;
  assign mul_b  = op_b;
  assign res_z  = res_z_q;
  assign res_id = id;
  assign err    = err_q;

endmodule

// File: doc/fm_arbiter.md
# fm_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle FP32 multiplier (`fm`) between `N_REQ` requesters in the fully-connected datapath. It accepts one operand pair per grant and drives the multiplier's enable for exactly one full 8-cycle pass. It then captures the product and returns it, tagged with the requester index, over a valid/ready result port. Requesters are the per-neuron MAC lanes; the result port feeds the accumulator stage.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: result tag width, equal to clog2(`N_REQ`).
- `LAT`, default 8: enable cycles per multiply. Fixed by `fm`; not user-tunable.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`. The same `rst_n` drives the attached `fm`.
- `req`  in  N_REQ  per-requester request level.
- `a_in`  in  N_REQ*32  operand A. Lane i is `[32*i+31:32*i]`.
- `b_in`  in  N_REQ*32  operand B, same packing as `a_in`.
- `gnt`  out  N_REQ  one-hot, 1-cycle acceptance pulse. The lane's operands are sampled on this cycle.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_z`  out  32  FP32 product.
- `res_id`  out  ID_W  index of the requester that owns `res_z`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky; `mul_valid` was missing at capture.
- `mul_v`  out  1  multiplier enable.
- `mul_a`, `mul_b`  out  32  multiplier operands.
- `mul_z`  in  32  multiplier result.
- `mul_valid`  in  1  multiplier done flag.

## Operation
- The FSM has four states: IDLE, RUN, CAP, OUT.
- **IDLE**
  - If any `req` bit is set, pick the winner round-robin, searching from `last+1` mod N_REQ upward.
  - Assert `gnt[winner]` combinationally in this cycle.
  - Register `a_in`/`b_in` of the winner into `op_a`/`op_b`, register `id`, set `last` to the winner, and go to RUN.
  - If no request is pending, stay in IDLE with `gnt` at 0.
- **RUN**
  - `mul_v`=1 and `cnt` increments from 0.
  - When `cnt`==LAT-1, clear `cnt` and go to CAP.
  - `mul_v` must be high for exactly LAT consecutive cycles per operation. The multiplier's internal phase counter is never reset between operations, so any other count desynchronises it.
- **CAP**
  - `mul_v`=0.
  - Register `mul_z` into `res_z`.
  - If `mul_valid`==0, set `err`.
  - Go to OUT.
- **OUT**
  - `res_valid`=1, with `res_z`/`res_id` held stable.
  - On `res_valid && res_ready`, go to IDLE.
- `mul_valid` is sampled only in CAP. Its level is ignored in every other state, because it stays high after completion until the next enable.
- `mul_a`/`mul_b` are driven from `op_a`/`op_b` continuously and change only on a grant.
- Requester obligation: drop `req` in the cycle after `gnt` unless it has a further operand pair to submit. A held `req` is treated as a new request.
- `err` clears only on reset.

## Timing
- Values after reset: `gnt`=0, `res_valid`=0, `res_z`=0, `res_id`=0, `busy`=0, `err`=0, `mul_v`=0, `mul_a`=`mul_b`=0, `last`=N_REQ-1 (so lane 0 wins first), `cnt`=0, state IDLE.
- Reset asserted mid-operation aborts immediately. The in-flight result is discarded and `mul_v` drops at once.
- Cycle sequence with the grant in cycle 0:
  - cycles 1..LAT: RUN.
  - cycle LAT+1: CAP.
  - cycle LAT+2: `res_valid` first high.
- Minimum grant-to-grant interval is LAT+3 cycles, reached with `res_ready` held at 1.
- Backpressure: OUT holds indefinitely while `res_ready` is low. `req` stays pending and nothing is dropped.
- New requests arriving in RUN, CAP or OUT wait. The round-robin decision is made only in IDLE.
- Simultaneous requests from all lanes are granted in rotation 0,1,2,3,0,…; no lane is granted twice before every other pending lane.

## Structure
- Package `fm_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, CAP, OUT);
  - `FP_W`=32;
  - `FM_LAT`=8;
  - constants `FP_QNAN`=32'hFFC00000 and `FP_POS_INF`=32'h7F800000, for the bench.
- Sub-module `rr_pick`:
  - parameterised on N_REQ;
  - inputs `req` and `last`;
  - outputs `onehot` grant and encoded `idx`;
  - purely combinational, built as a double-width rotate-and-priority-encode.
- The FSM, counter and result registers live in `fm_arbiter`.

## Test plan
- Single lane 0: `a`=0x40000000, `b`=0x40400000 → `gnt`=0001 in cycle 0, `mul_v` high for exactly 8 cycles, `res_valid` at cycle 10 with `res_z`=0x40C00000 and `res_id`=0; `err`=0.
- All four lanes request continuously with `res_ready`=1 → grants in order 0,1,2,3,0, spaced 11 cycles apart; `res_id` follows the same sequence.
- `res_ready` held low for 20 cycles after `res_valid` → `res_z`/`res_id` stable and no new `gnt` during the stall; next grant in the cycle after the handshake.
- Special values: 0x7F800000 × 0x00000000 → 0xFFC00000; 0x3F800000 × 0xBF800000 → 0xBF800000.
- Reset asserted in RUN cycle 4 → all outputs return to reset values; a subsequent 0x3FC00000 × 0x40000000 → 0x40400000 with `err`=0.
- Fault injection: bench model forces `mul_valid`=0 at CAP → `err` goes and stays 1; `res_valid` is still delivered.
